cdiv_seq: RTL and testbench



---
 rtl/cdiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_cdiv_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cdiv_seq.sv
// Sequential fixed-point complex divider q = a*conj(b)/|b|^2 with one restoring divide loop per component.
// Define CDIV_ROUND_EN to add a guard-bit iteration and round half away from zero (latency N+2 instead of N+1).
module cdiv_seq #(
    parameter int unsigned Q = 8,
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] ar,
    input  logic [N-1:0] ai,
    input  logic [N-1:0] br,
    input  logic [N-1:0] bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] qr,
    output logic [N-1:0] qi,
    output logic         ovr,
    output logic         div0
);

    localparam int unsigned W1   = 2 * N + 1;
    localparam int unsigned DENW = 2 * N;
    localparam int unsigned DW   = 3 * N;
    localparam int unsigned CW   = $clog2(N) + 1;
`ifdef CDIV_ROUND_EN
    localparam int unsigned ITER = N;
    localparam int unsigned SH   = Q + 1;
`else
    localparam int unsigned ITER = N - 1;
    localparam int unsigned SH   = Q;
`endif
    localparam logic [N-1:0]  MAX_POS  = {1'b0, {(N-1){1'b1}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        DIV  = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nx;

    logic signed [N-1:0] ar_q, ai_q, br_q, bi_q;
    logic [DW-1:0]       rem_r, rem_i, dsh;
    logic [N-1:0]        quo_r, quo_i;
    logic [CW-1:0]       cnt;
    logic                sgn_r, sgn_i, sat_r, sat_i, dz;

    logic signed [W1-1:0]   nr_c, ni_c;
    logic signed [DENW-1:0] br2_c, bi2_c;
    logic [W1-1:0]          mag_nr_c, mag_ni_c;
    logic [DENW-1:0]        den_c;
    logic [DW-1:0]          dvd_r_c, dvd_i_c, den_ext_c;
    logic                   ge_r_c, ge_i_c;
    logic [N:0]             fin_r_c, fin_i_c;

    // Magnitude quotient -> signed result with symmetric saturation; bit N is the overflow flag.
    function automatic logic [N:0] finish_val(input logic sgn, input logic sat, input logic [N-1:0] quo);
        logic [N-1:0] mag;
        logic         ovf;
        logic [N-1:0] val;
`ifdef CDIV_ROUND_EN
        mag = (quo >> 1) + N'(quo[0]);
`else
        mag = quo;
`endif
        ovf = sat | mag[N-1];
        if (ovf) begin
            val = sgn ? (~MAX_POS + N'(1)) : MAX_POS;
        end else if (mag == '0) begin
            val = '0;
        end else begin
            val = sgn ? (~mag + N'(1)) : mag;
        end
        return {ovf, val};
    endfunction

    // Cross products, divisor energy and the per-component dividends.
    always_comb begin
        nr_c      = W1'(ar_q) * W1'(br_q) + W1'(ai_q) * W1'(bi_q);
        ni_c      = W1'(ai_q) * W1'(br_q) - W1'(ar_q) * W1'(bi_q);
        br2_c     = DENW'(br_q) * DENW'(br_q);
        bi2_c     = DENW'(bi_q) * DENW'(bi_q);
        den_c     = $unsigned(br2_c) + $unsigned(bi2_c);
        mag_nr_c  = nr_c[W1-1] ? W1'(-nr_c) : W1'(nr_c);
        mag_ni_c  = ni_c[W1-1] ? W1'(-ni_c) : W1'(ni_c);
        dvd_r_c   = DW'(mag_nr_c) << SH;
        dvd_i_c   = DW'(mag_ni_c) << SH;
        den_ext_c = DW'(den_c);
        ge_r_c    = rem_r >= dsh;
        ge_i_c    = rem_i >= dsh;
        fin_r_c   = finish_val(sgn_r, sat_r, quo_r);
        fin_i_c   = finish_val(sgn_i, sat_i, quo_i);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = PREP;
            PREP:    state_nx = DIV;
            DIV:     if (cnt == '0) state_nx = FIN;
            FIN:     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, restoring divide loop, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q  <= '0;
            ai_q  <= '0;
            br_q  <= '0;
            bi_q  <= '0;
            rem_r <= '0;
            rem_i <= '0;
            dsh   <= '0;
            quo_r <= '0;
            quo_i <= '0;
            cnt   <= '0;
            sgn_r <= 1'b0;
            sgn_i <= 1'b0;
            sat_r <= 1'b0;
            sat_i <= 1'b0;
            dz    <= 1'b0;
            qr    <= '0;
            qi    <= '0;
            ovr   <= 1'b0;
            div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ar_q <= ar;
                        ai_q <= ai;
                        br_q <= br;
                        bi_q <= bi;
                    end
                end
                PREP: begin
                    rem_r <= dvd_r_c;
                    rem_i <= dvd_i_c;
                    dsh   <= den_ext_c << (ITER - 1);
                    quo_r <= '0;
                    quo_i <= '0;
                    cnt   <= CNT_LAST;
                    sgn_r <= nr_c[W1-1];
                    sgn_i <= ni_c[W1-1];
                    sat_r <= dvd_r_c >= (den_ext_c << ITER);
                    sat_i <= dvd_i_c >= (den_ext_c << ITER);
                    dz    <= den_c == '0;
                end
                DIV: begin
                    if (ge_r_c) rem_r <= rem_r - dsh;
                    if (ge_i_c) rem_i <= rem_i - dsh;
                    quo_r <= {quo_r[N-2:0], ge_r_c};
                    quo_i <= {quo_i[N-2:0], ge_i_c};
                    dsh   <= dsh >> 1;
                    cnt   <= cnt - CW'(1);
                end
                FIN: begin
                    // A zero divisor overrides whatever the loop produced.
                    qr   <= dz ? '0 : fin_r_c[N-1:0];
                    qi   <= dz ? '0 : fin_i_c[N-1:0];
                    ovr  <= ~dz & (fin_r_c[N] | fin_i_c[N]);
                    div0 <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdiv_seq.sv
// Directed bench for cdiv_seq (N=16, Q=8): results, flags, latency, back-pressure and mid-op reset.
module tb_cdiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ar, ai, br, bi;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] qr, qi;
    logic        ovr, div0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

`ifdef CDIV_ROUND_EN
    localparam int LAT = 18;
    localparam logic [15:0] Q_2_3 = 16'h00AB;
`else
    localparam int LAT = 17;
    localparam logic [15:0] Q_2_3 = 16'h00AA;
`endif

    cdiv_seq #(.Q(8), .N(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .qr(qr), .qi(qi), .ovr(ovr), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a_r, input logic [15:0] a_i,
                            input logic [15:0] b_r, input logic [15:0] b_i);
        @(negedge clk);
        ar = a_r; ai = a_i; br = b_r; bi = b_i;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (out_valid !== 1'b1 && l < 60) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [15:0] a_r, input logic [15:0] a_i,
                          input logic [15:0] b_r, input logic [15:0] b_i,
                          input logic [15:0] e_qr, input logic [15:0] e_qi,
                          input logic e_ovr, input logic e_div0);
        int l;
        start_op(a_r, a_i, b_r, b_i);
        wait_valid(l);
        chk({tag, "_lat"}, 32'(l), 32'(LAT));
        chk({tag, "_qr"}, 32'(qr), 32'(e_qr));
        chk({tag, "_qi"}, 32'(qi), 32'(e_qi));
        chk({tag, "_ovr"}, 32'(ovr), 32'(e_ovr));
        chk({tag, "_div0"}, 32'(div0), 32'(e_div0));
        @(posedge clk);
        #1 chk({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ar = '0; ai = '0; br = '0; bi = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", {qr, qi}, 32'd0);
        chk("rst_flags", {30'd0, ovr, div0}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("unit",   16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
        run_op("j_over", 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0080, 1'b0, 1'b0);
        run_op("m3p4j",  16'hFD00, 16'h0400, 16'h0000, 16'h0100, 16'h0400, 16'h0300, 1'b0, 1'b0);
        run_op("sat_p",  16'h6400, 16'h0000, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        run_op("sat_n",  16'h9C00, 16'h0000, 16'h0001, 16'h0000, 16'h8001, 16'h0000, 1'b1, 1'b0);
        run_op("div0",   16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        run_op("two_3",  16'h0200, 16'h0000, 16'h0300, 16'h0000, Q_2_3,    16'h0000, 1'b0, 1'b0);
        // -1/4 with truncation magnitude 0x40 -> 0xFFC0; tiny 1/256 over 4 truncates to +0
        run_op("neg_q",  16'hFF00, 16'h0000, 16'h0400, 16'h0000, 16'hFFC0, 16'h0000, 1'b0, 1'b0);

        // Back-pressure: result held while out_ready is low, new operands ignored.
        out_ready = 1'b0;
        start_op(16'hFD00, 16'h0400, 16'h0000, 16'h0100);
        wait_valid(lat);
        chk("hold_lat", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            ar = 16'h0100; ai = 16'h0000; br = 16'h0100; bi = 16'h0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_q", {qr, qi}, {16'h0400, 16'h0300});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("hold_release", 32'(out_valid), 32'd0);
        chk("hold_idle", 32'(in_ready), 32'd1);

        // Reset during DIV discards the operation.
        start_op(16'h6400, 16'h0000, 16'h0001, 16'h0000);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_q", {qr, qi}, 32'd0);
        chk("mid_rst_flags", {30'd0, ovr, div0}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op("post_rst", 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0080, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
